// File: rtl/block_memory.sv
// Block-granular main memory behind the L2: latency-configurable block reads, single-cycle writes.
// Optional 16-bit read/write statistics counters are compiled in with BLOCK_MEMORY_STATS_EN.
module block_memory #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 11,
   parameter int BLOCK_SIZE   = 32,
   parameter int READ_LATENCY = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [ADDR_WIDTH-1:0]                 mem_addr,
   input  logic                                  mem_read,
   input  logic                                  mem_write,
   input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
   output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block,
   output logic                                  mem_ready
`ifdef BLOCK_MEMORY_STATS_EN
   ,
   output logic [15:0]                           read_count,
   output logic [15:0]                           write_count
`endif
);

   localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
   localparam int BLK_W        = ADDR_WIDTH - OFFSET_WIDTH;
   localparam int NUM_BLOCKS   = 2 ** BLK_W;
   localparam logic [7:0] CNT_LOAD = 8'(READ_LATENCY - 1);

   typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [7:0]       cnt, cnt_nxt;
   logic [BLK_W-1:0] rd_blk, rd_blk_nxt, req_blk;
   logic             rd_prev, rd_start;
   logic             unused_offset;

   block_t mem_array [NUM_BLOCKS];

   assign req_blk       = mem_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
   assign unused_offset = ^mem_addr[OFFSET_WIDTH-1:0];

   // The L2 holds mem_read past mem_ready and drives the address only once, so accept on the rising edge.
   assign rd_start = mem_read & ~rd_prev & (state == IDLE);

   always_comb begin
      state_nxt  = IDLE;
      cnt_nxt    = cnt;
      rd_blk_nxt = rd_blk;
      case (state)
         IDLE: begin
            if (rd_start) begin
               rd_blk_nxt = req_blk;
               cnt_nxt    = CNT_LOAD;
               state_nxt  = (READ_LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (!mem_read) begin
               state_nxt = IDLE;
            end else if (cnt <= 8'd1) begin
               cnt_nxt   = 8'd0;
               state_nxt = RESP;
            end else begin
               cnt_nxt   = cnt - 8'd1;
               state_nxt = WAIT;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Array is sampled as RESP is registered: earlier writes are seen, a same-cycle write is not.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= 8'd0;
         rd_blk         <= '0;
         rd_prev        <= 1'b0;
         mem_ready      <= 1'b0;
         mem_data_block <= '0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         rd_blk         <= rd_blk_nxt;
         rd_prev        <= mem_read;
         mem_ready      <= (state_nxt == RESP);
         mem_data_block <= (state_nxt == RESP) ? mem_array[rd_blk_nxt] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_write) begin
         mem_array[req_blk] <= mem_data_out;
      end
   end

`ifdef BLOCK_MEMORY_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         read_count  <= 16'd0;
         write_count <= 16'd0;
      end else begin
         if (state == RESP && read_count != 16'hFFFF) begin
            read_count <= read_count + 16'd1;
         end
         if (mem_write && write_count != 16'hFFFF) begin
            write_count <= write_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_block_memory.sv
// Scoreboard bench for block_memory: directed L2-style transactions, monitor checks data, latency and idle outputs.
// Stats ports are exercised when BLOCK_MEMORY_STATS_EN is defined.
module tb_block_memory;

   localparam int DW = 32;
   localparam int AW = 11;
   localparam int BS = 32;
   localparam int RL = 4;

   typedef logic [BS-1:0][DW-1:0] blk_t;
   typedef struct {
      blk_t data;
      int   due;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [AW-1:0] mem_addr;
   logic          mem_read;
   logic          mem_write;
   blk_t          mem_data_out;
   blk_t          mem_data_block;
   logic          mem_ready;
`ifdef BLOCK_MEMORY_STATS_EN
   logic [15:0]   read_count;
   logic [15:0]   write_count;
`endif

   block_memory #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .READ_LATENCY(RL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mem_addr(mem_addr),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_data_out(mem_data_out),
      .mem_data_block(mem_data_block),
      .mem_ready(mem_ready)
`ifdef BLOCK_MEMORY_STATS_EN
      ,
      .read_count(read_count),
      .write_count(write_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   exp_rd = 0;
   int   exp_wr = 0;
   bit   mon_en = 1'b0;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic blk_t ramp(input logic [31:0] base);
      blk_t b;
      for (int i = 0; i < BS; i++) b[i] = base + 32'(i);
      return b;
   endfunction

   function automatic blk_t fill(input logic [31:0] v);
      blk_t b;
      for (int i = 0; i < BS; i++) b[i] = v;
      return b;
   endfunction

   function automatic int diff_idx(input blk_t a, input blk_t b);
      for (int i = 0; i < BS; i++) if (a[i] !== b[i]) return i;
      return 0;
   endfunction

   // Monitor: every mem_ready pops one expectation; outside a response outputs must be zero.
   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_ready === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_ready cyc=%0d got mem_ready=1 want 0", cyc);
            end else begin
               exp_t e;
               int   k;
               e = sb.pop_front();
               k = diff_idx(mem_data_block, e.data);
               if (mem_data_block !== e.data) begin
                  n_bad++;
                  $display("FAIL resp_data cyc=%0d word[%0d] got %h want %h", cyc, k, mem_data_block[k], e.data[k]);
               end else if (cyc != e.due) begin
                  n_bad++;
                  $display("FAIL resp_latency got cycle %0d want %0d", cyc, e.due);
               end
            end
         end else begin
            n_vec++;
            if (mem_ready !== 1'b0 || mem_data_block !== '0) begin
               n_bad++;
               $display("FAIL idle_outputs cyc=%0d got ready=%b word0=%h want 0/0", cyc, mem_ready, mem_data_block[0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input blk_t d);
      exp_t e;
      e.data = d;
      e.due  = cyc + RL;
      sb.push_back(e);
      exp_rd++;
   endtask

   task automatic wr(input logic [AW-1:0] a, input blk_t d);
      mem_write    = 1'b1;
      mem_addr     = a;
      mem_data_out = d;
      exp_wr++;
      tick();
      mem_write    = 1'b0;
      mem_addr     = '0;
      mem_data_out = '0;
   endtask

   // L2-style read: address only in the first cycle, mem_read held through ready+1.
   task automatic rd(input logic [AW-1:0] a, input blk_t d);
      mem_read = 1'b1;
      mem_addr = a;
      push_exp(d);
      tick();
      mem_addr = '0;
      repeat (RL + 1) tick();
      mem_read = 1'b0;
      tick();
   endtask

   task automatic check_idle(input string name);
      n_vec++;
      if (mem_ready !== 1'b0 || mem_data_block !== '0) begin
         n_bad++;
         $display("FAIL %s got ready=%b word0=%h want 0/0", name, mem_ready, mem_data_block[0]);
      end
`ifdef BLOCK_MEMORY_STATS_EN
      n_vec++;
      if (read_count !== 16'd0 || write_count !== 16'd0) begin
         n_bad++;
         $display("FAIL %s_counts got rd=%0d wr=%0d want 0/0", name, read_count, write_count);
      end
`endif
   endtask

   initial begin
      rst          = 1'b1;
      mem_addr     = '0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_data_out = '0;
      repeat (2) tick();
      rst = 1'b0;
      check_idle("reset_state");
      mon_en = 1'b1;

      wr(11'h040, ramp(32'hA000_0000));
      tick();
      rd(11'h040, ramp(32'hA000_0000));
      rd(11'h05F, ramp(32'hA000_0000));
      wr(11'h7E0, ramp(32'hB000_0000));
      rd(11'h7E7, ramp(32'hB000_0000));

      // Write to the pending block two cycles after the read edge.
      mem_read = 1'b1;
      mem_addr = 11'h040;
      push_exp(fill(32'h5555_5555));
      tick();
      mem_addr = '0;
      tick();
      wr(11'h040, fill(32'h5555_5555));
      repeat (RL - 1) tick();
      mem_read = 1'b0;
      tick();

      // Write in the cycle RESP is registered: response keeps the old block.
      mem_read = 1'b1;
      mem_addr = 11'h7E0;
      push_exp(ramp(32'hB000_0000));
      tick();
      mem_addr = '0;
      repeat (2) tick();
      wr(11'h7E0, ramp(32'hC000_0000));
      repeat (RL - 2) tick();
      mem_read = 1'b0;
      tick();
      rd(11'h7E0, ramp(32'hC000_0000));

      // Read and write together on the same block.
      mem_read     = 1'b1;
      mem_write    = 1'b1;
      mem_addr     = 11'h0A0;
      mem_data_out = ramp(32'hD000_0000);
      push_exp(ramp(32'hD000_0000));
      exp_wr++;
      tick();
      mem_write    = 1'b0;
      mem_addr     = '0;
      mem_data_out = '0;
      repeat (RL + 1) tick();
      mem_read = 1'b0;
      tick();

      // Abort at T+2: no response expected, then a fresh edge is served.
      mem_read = 1'b1;
      mem_addr = 11'h040;
      tick();
      mem_addr = '0;
      tick();
      mem_read = 1'b0;
      repeat (8) tick();
      rd(11'h040, fill(32'h5555_5555));

      // Reset at T+1 of a read: response dropped, array contents kept.
      mem_read = 1'b1;
      mem_addr = 11'h7E0;
      tick();
      mem_addr = '0;
      mem_read = 1'b0;
      rst      = 1'b1;
      tick();
      rst    = 1'b0;
      exp_rd = 0;
      exp_wr = 0;
      check_idle("reset_mid_read");
      repeat (6) tick();
      rd(11'h7E0, ramp(32'hC000_0000));
      wr(11'h020, ramp(32'hE000_0000));
      rd(11'h020, ramp(32'hE000_0000));

      repeat (3) tick();
      n_vec++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL missing_responses got %0d outstanding want 0", sb.size());
      end
`ifdef BLOCK_MEMORY_STATS_EN
      n_vec++;
      if (read_count !== 16'(exp_rd)) begin
         n_bad++;
         $display("FAIL read_count got %0d want %0d", read_count, exp_rd);
      end
      n_vec++;
      if (write_count !== 16'(exp_wr)) begin
         n_bad++;
         $display("FAIL write_count got %0d want %0d", write_count, exp_wr);
      end
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/block_memory.md
# block_memory

Main-memory responder for the L2 cache's memory interface: the backing store that serves block reads and absorbs write-through block writes. It sits below the L2 cache and connects port-for-port to the L2 memory signals (`mem_addr`, `mem_read`, `mem_write`, `mem_data_out`, `mem_data_block`, `mem_ready`). Reads complete after a configurable latency, and writes are accepted in a single cycle. It serves as the system memory model in simulation and as a synthesizable block RAM wrapper on FPGA.

## Interface
- `DATA_WIDTH`, default 32: bits per word.
- `ADDR_WIDTH`, default 11: byte/word address width, matching the L2.
- `BLOCK_SIZE`, default 32: words per block.
- `READ_LATENCY`, default 4: cycles from read acceptance to `mem_ready`; legal range 1..255.
- Derived: `OFFSET_WIDTH = $clog2(BLOCK_SIZE)`, `NUM_BLOCKS = 2**(ADDR_WIDTH-OFFSET_WIDTH)`, default 64.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_addr`  in  `ADDR_WIDTH`  block address; offset bits ignored; valid only in request cycles.
- `mem_read`  in  1  read request level from the L2.
- `mem_write`  in  1  write request; one-cycle pulse.
- `mem_data_out`  in  `[BLOCK_SIZE-1:0][DATA_WIDTH-1:0]`  write block from the L2.
- `mem_data_block`  out  `[BLOCK_SIZE-1:0][DATA_WIDTH-1:0]`  read block, registered.
- `mem_ready`  out  1  read-data-valid pulse, registered.
- `read_count`, `write_count`  out  16 each  only present under `BLOCK_MEMORY_STATS_EN`.

## Operation
- Storage: `NUM_BLOCKS` x block array, indexed by `blk = mem_addr[ADDR_WIDTH-1:OFFSET_WIDTH]`. Reset does not clear the array.
- Read acceptance is edge-based: `rd_start = mem_read & ~rd_prev & (state==IDLE)`.
  - `rd_prev` is a register of `mem_read`; reset value 0.
  - Edge detection is required because the L2 drives `mem_addr` only in its first request cycle (0 afterwards) and holds `mem_read` one cycle past `mem_ready`.
- On `rd_start`, latch `blk` into `rd_blk`, load the counter with `READ_LATENCY-1`, and go to WAIT.
- FSM:
  - IDLE: on `rd_start`, go to WAIT; if `READ_LATENCY==1`, go directly to RESP.
  - WAIT: decrement the counter. When it reaches 0, go to RESP. If `mem_read==0` (abort), go to IDLE with no response.
  - RESP: `mem_ready=1` and `mem_data_block=array[rd_blk]` for exactly one cycle, then go to IDLE.
  - Encoding is unreachable-safe: any illegal state goes to IDLE.
- Writes: when `mem_write==1`, `array[blk] <= mem_data_out` in that cycle, in any state. There is never backpressure.
- Simultaneous events:
  - Write to `rd_blk` while in WAIT: the response returns the new data, because the array is read when RESP is registered.
  - Write in the same cycle as the RESP registration: the response returns the old data.
  - `mem_read` and `mem_write` high in the same cycle: both are processed, and the read latches the address.
  - `mem_read` rising while not in IDLE: ignored. It is not queued.
- Outputs outside RESP: `mem_ready=0` and `mem_data_block=0`.

## Timing
- Reset values (asserted in the cycle after `rst` is sampled high):
  - State IDLE, `mem_ready=0`, `mem_data_block=0`, `rd_prev=0`.
  - Counters 0, when present.
- `rst` mid-read: the pending read is dropped and no `mem_ready` is issued.
- Read latency: `rd_start` sampled in cycle T gives `mem_ready` high in cycle T+`READ_LATENCY`, for one cycle only.
- With the L2 protocol, `mem_read` stays high through cycle T+`READ_LATENCY`+1. That cycle is not a new request because `rd_prev==1`.
- Minimum spacing between accepted reads is `READ_LATENCY`+2 cycles: RESP, then `mem_read` must go low for one cycle.
- Write latency: 0. Data is visible to a read whose RESP is registered in a later cycle.

## Configuration
- `BLOCK_MEMORY_STATS_EN` defined:
  - Adds 16-bit `read_count` (increments on each RESP cycle) and `write_count` (increments on each `mem_write` cycle).
  - Both saturate at 16'hFFFF and reset to 0.
  - Aborted reads are not counted.
- Not defined: the ports and counters are absent and the rest of the behaviour is identical.

## Test plan
- Write/read: pulse `mem_write` with `mem_addr=11'h040` and block word[i]=32'hA000_0000+i; later raise `mem_read` with addr 11'h040 and `READ_LATENCY=4` -> `mem_ready` exactly 4 cycles after the edge, data word[i]=32'hA000_0000+i, single pulse.
- L2 handshake: `mem_addr` valid only in the first `mem_read` cycle (0 afterwards), `mem_read` held through ready+1 -> exactly one response, correct block, no second request.
- Write during WAIT: read block 2, then write block 2 with 32'h5555_5555 words two cycles later -> response carries 32'h5555_5555.
- Abort: drop `mem_read` at cycle T+2 of a latency-4 read -> no `mem_ready`; a new edge later is accepted normally.
- Reset mid-read: assert `rst` at T+1 -> `mem_ready` stays 0, outputs are 0, and a previously written block still reads back correctly after reset.
- Stats (`BLOCK_MEMORY_STATS_EN`): 3 writes, 2 completed reads, 1 aborted read -> `write_count=3`, `read_count=2`.
